// File: rtl/pe_stream_feeder.sv
// Double-buffered frame feeder: upstream fills one bank while the other bank
// is streamed word-per-cycle into the PE array, framed by arr_rst_out.
module pe_stream_feeder #(
  parameter int ROW_LENGTH = 11,
  parameter int O_CH       = 6,
  parameter int FRAME_LEN  = O_CH * ROW_LENGTH + ROW_LENGTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_valid,
  input  logic [26:0] wr_data,
  output logic        wr_ready,
  output logic        arr_rst_out,
  output logic [26:0] arr_data_out,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        dbg_state_out
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  // Handshake: a word transfers on a rising edge where wr_valid and wr_ready
  // are both 1; wr_ready depends only on registered state, never on wr_valid.

  logic [26:0]   r_mem [0:1][0:FRAME_LEN-1];
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic [IW-1:0] r_wr_idx;
  state_t        r_state;
  logic          r_rd_bank;
  logic [IW-1:0] r_rd_idx;
  logic          r_arr_rst;
  logic [26:0]   r_arr_data;
  logic          r_frame_done;
  logic [7:0]    r_frame_cnt;

  logic          w_wr_fire;
  logic          w_frame_end;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;
  state_t        w_next_state;
  logic          w_next_rd_bank;
  logic [IW-1:0] w_next_rd_idx;
  logic          w_next_arr_rst;
  logic          w_next_done;
  logic          w_sel_bank;
  logic [IW-1:0] w_sel_idx;
  logic [26:0]   w_next_data;

  assign wr_ready      = ~r_full[r_wr_bank];
  assign w_wr_fire     = wr_valid & wr_ready;
  assign w_frame_end   = (r_state == S_STREAM) && (r_rd_idx == LAST);
  assign w_full_set    = (w_wr_fire && (r_wr_idx == LAST)) ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_full_clr    = w_frame_end ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge clk_in) begin
    if (w_wr_fire) r_mem[r_wr_bank][r_wr_idx] <= wr_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_full    <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
      if (w_wr_fire) begin
        if (r_wr_idx == LAST) begin
          r_wr_idx  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_idx <= r_wr_idx + IW'(1);
        end
      end
    end
  end

  // Back-to-back decision uses the registered full flag of the other bank,
  // so a bank completing on the frame-end edge costs one idle cycle.
  always_comb begin
    w_next_state   = r_state;
    w_next_rd_bank = r_rd_bank;
    w_next_rd_idx  = r_rd_idx;
    w_next_arr_rst = 1'b0;
    w_next_done    = 1'b0;
    w_sel_bank     = r_rd_bank;
    w_sel_idx      = '0;
    case (r_state)
      S_IDLE: begin
        w_next_rd_idx = '0;
        if (r_full[r_rd_bank]) begin
          w_next_state   = S_STREAM;
          w_next_arr_rst = 1'b1;
          w_next_done    = (LAST == '0);
        end
      end
      S_STREAM: begin
        if (w_frame_end) begin
          w_next_rd_bank = ~r_rd_bank;
          w_next_rd_idx  = '0;
          w_sel_bank     = ~r_rd_bank;
          if (r_full[~r_rd_bank]) begin
            w_next_arr_rst = 1'b1;
            w_next_done    = (LAST == '0);
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_rd_idx  = r_rd_idx + IW'(1);
          w_sel_idx      = r_rd_idx + IW'(1);
          w_next_arr_rst = 1'b1;
          w_next_done    = ((r_rd_idx + IW'(1)) == LAST);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_next_data = w_next_arr_rst ? r_mem[w_sel_bank][w_sel_idx] : 27'd0;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_rd_bank    <= 1'b0;
      r_rd_idx     <= '0;
      r_arr_rst    <= 1'b0;
      r_arr_data   <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state      <= w_next_state;
      r_rd_bank    <= w_next_rd_bank;
      r_rd_idx     <= w_next_rd_idx;
      r_arr_rst    <= w_next_arr_rst;
      r_arr_data   <= w_next_data;
      r_frame_done <= w_next_done;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign arr_rst_out   = r_arr_rst;
  assign arr_data_out  = r_arr_data;
  assign frame_done    = r_frame_done;
  assign frame_cnt     = r_frame_cnt;
  assign dbg_state_out = r_state;

endmodule

// File: doc/pe_stream_feeder.md
PE_STREAM_FEEDER -- requirements
Module: pe_stream_feeder

Interface
REQ-001 SHALL have parameter ROW_LENGTH, default 11: activation words per frame.
REQ-002 SHALL have parameter O_CH, default 6: output channels (weight rows).
REQ-003 SHALL have parameter FRAME_LEN, default O_CH*ROW_LENGTH+ROW_LENGTH (77): words per frame.
REQ-004 SHALL have port clk_in  input  1  clock; one clock domain, rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  1  upstream word valid.
REQ-007 SHALL have port wr_data  input  27  upstream word: weights first (O_CH*ROW_LENGTH), then activations (ROW_LENGTH).
REQ-008 SHALL have port wr_ready  output  1  feeder can accept a word.
REQ-009 SHALL have port arr_rst_out  output  1  active-low synchronous reset driven to the PE array.
REQ-010 SHALL have port arr_data_out  output  27  word stream to the PE array data input.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse while the last word of a frame is presented.
REQ-012 SHALL have port frame_cnt  output  8  count of frames fully streamed, wraps 255->0.

Function
REQ-013 SHALL hold two banks (bank 0, bank 1) of FRAME_LEN x 27 bits, each with a full flag.
REQ-014 SHALL accept a word on a rising edge with wr_valid=1 and wr_ready=1, and store it at wr_idx of bank wr_bank.
REQ-015 SHALL drive wr_ready = NOT full[wr_bank], combinationally.
REQ-016 SHALL, on accepting word at wr_idx=FRAME_LEN-1, set full[wr_bank], clear wr_idx to 0 and toggle wr_bank on that edge.
REQ-017 SHALL implement reader FSM states IDLE and STREAM, with rd_bank (init 0) and rd_idx (0..FRAME_LEN-1).
REQ-018 SHALL, in IDLE, register arr_rst_out=0 and arr_data_out=0.
REQ-019 SHALL, on the edge where IDLE observes full[rd_bank]=1 (registered value), enter STREAM with arr_rst_out=1 and arr_data_out=word 0.
REQ-020 SHALL, in STREAM, present word k of rd_bank in the k-th cycle after entry (k=0..FRAME_LEN-1), one word per cycle, no stalls.
REQ-021 SHALL assert frame_done during the cycle word FRAME_LEN-1 is presented.
REQ-022 SHALL, on the edge ending that cycle: clear full[rd_bank], toggle rd_bank, increment frame_cnt.
REQ-023 SHALL, on that same edge, present word 0 of the other bank with arr_rst_out held 1 if its registered full flag is 1.
REQ-024 SHALL otherwise go to IDLE with arr_rst_out=0 for at least one cycle.
REQ-025 SHALL use registered full flags for the REQ-023 decision: a bank completing on that same edge is not seen, giving exactly one IDLE cycle.
REQ-026 SHALL stream frames in write-completion order; word order within a frame is unchanged.
REQ-027 SHALL let a freed bank accept writes on the cycle after it is cleared.

Reset
REQ-028 SHALL, on rst_in=0 (asynchronous, any cycle), immediately force: arr_rst_out=0, arr_data_out=0, frame_done=0, frame_cnt=0, FSM=IDLE, both full flags=0, wr_bank=rd_bank=0, wr_idx=rd_idx=0.
REQ-029 SHALL, as a result, assert wr_ready=1 during reset.
REQ-030 SHALL discard partially written and in-flight frames on reset mid-operation; bank contents need not be cleared.

Verification
REQ-031 SHALL cover: reset, 77 back-to-back words 1..77 -> wr_ready stays 1; arr_rst_out=1 from edge after word 77 accepted; arr_data_out 1..77 over 77 cycles; frame_done in 77th cycle; then arr_rst_out=0; frame_cnt=1.
REQ-032 SHALL cover: 154 back-to-back words -> 154 consecutive outputs, arr_rst_out never drops between frames, frame_cnt=2.
REQ-033 SHALL cover: 231 back-to-back words -> wr_ready=0 after word 154 accepted until bank 0 freed; all 231 words emitted in order.
REQ-034 SHALL cover: second frame's last word accepted on the same edge the first frame ends -> arr_rst_out=0 for exactly one cycle, then second frame streams.
REQ-035 SHALL cover: rst_in=0 while word 40 is presented -> arr_rst_out=0 and arr_data_out=0 without waiting for a clock edge; wr_ready=1; frame_cnt=0; next 77 writes stream normally.
REQ-036 SHALL cover: random wr_valid gaps over 5 frames -> output equals input sequence; frame_cnt=5.
